// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem request channel, in-order response queue
// feeding decode, and a single redirect port that squashes all younger work.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_q_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_q_pc    [QDEPTH];
  logic [31:0]   r_q_instr [QDEPTH];

  logic          w_credit;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_dropping;
  logic          w_push;
  logic          w_head_valid;
  logic          w_pop;
  logic [31:0]   w_redir_pc;
  logic [CW-1:0] w_resp_dec;
  logic          w_unused;

  // Credits cover both in-flight and queued entries, so a push never finds the queue full.
  assign w_credit     = ({1'b0, r_out_cnt} + {1'b0, r_q_cnt}) < QD;
  assign w_req_valid  = !rst && !redirect_valid && w_credit;
  assign w_accept     = w_req_valid && imem_req_ready;
  assign w_dropping   = (r_drop_cnt != '0);
  assign w_push       = imem_resp_valid && !w_dropping && !redirect_valid;
  assign w_head_valid = (r_q_cnt != '0);
  assign w_pop        = w_head_valid && id_ready && !redirect_valid;
  assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
  assign w_resp_dec   = CW'(imem_resp_valid);
  assign w_unused     = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_q_cnt    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight, minus a response landing this cycle, must be discarded.
      r_pc       <= w_redir_pc;
      r_resp_pc  <= w_redir_pc;
      r_out_cnt  <= r_out_cnt - w_resp_dec;
      r_drop_cnt <= r_out_cnt - w_resp_dec;
      r_q_cnt    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end
      r_out_cnt <= r_out_cnt + CW'(w_accept) - w_resp_dec;
      if (imem_resp_valid && w_dropping) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
      r_q_instr[r_wr_ptr] <= imem_resp_data;
    end
  end

  always_comb begin
    imem_req_valid = w_req_valid;
    imem_req_addr  = rst ? 32'h0 : r_pc;
    id_valid       = !rst && w_head_valid;
    id_instr       = 32'h0;
    id_pc          = 32'h0;
    id_pc_plus4    = 32'h0;
    if (id_valid) begin
      id_instr    = r_q_instr[r_rd_ptr];
      id_pc       = r_q_pc[r_rd_ptr];
      id_pc_plus4 = r_q_pc[r_rd_ptr] + 32'd4;
    end
    id_opcode = id_instr[31:26];
    id_funct  = id_instr[5:0];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: bench memory model with configurable latency,
// expected request/decode queues filled by directed stimulus, checked by a monitor.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;

  instr_fetch_unit #(
    .RESET_PC(RST_PC),
    .QDEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_opcode      (id_opcode),
    .id_funct       (id_funct)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          lat = 1;
  int          first_acc = -1;
  int          first_vld = -1;
  logic [31:0] exp_req[$];
  exp_t        exp_pop[$];
  pend_t       pend[$];
  exp_t        e_mon;
  pend_t       p_mon;
  logic [31:0] e_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C22_0000 ^ {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add_req(input logic [31:0] a);
    exp_req.push_back(a);
  endtask

  task automatic add_pop(input logic [31:0] pc, input logic [31:0] p4);
    exp_t e;
    e.pc = pc;
    e.p4 = p4;
    exp_pop.push_back(e);
  endtask

  // Memory model plus monitor: respond at the falling edge, sample 3 units later.
  always @(negedge clk) begin
    cyc++;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
    #3;
    if (rst) begin
      pend.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        if (first_acc < 0) first_acc = cyc;
        acc_cnt++;
        if (exp_req.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual=%h expected=none", imem_req_addr);
        end else begin
          chk("req_addr", imem_req_addr, exp_req.pop_front());
        end
        p_mon.addr = imem_req_addr;
        p_mon.due  = cyc + lat;
        pend.push_back(p_mon);
      end
      if (id_valid && first_vld < 0) first_vld = cyc;
      if (id_valid && id_ready && !redirect_valid) begin
        if (exp_pop.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual=%h expected=none", id_pc);
        end else begin
          e_mon   = exp_pop.pop_front();
          e_instr = mem_word(e_mon.pc);
          chk("id_pc", id_pc, e_mon.pc);
          chk("id_pc_plus4", id_pc_plus4, e_mon.p4);
          chk("id_instr", id_instr, e_instr);
          chk("id_opcode", 32'(id_opcode), 32'(e_instr[31:26]));
          chk("id_funct", 32'(id_funct), 32'(e_instr[5:0]));
          if (e_mon.pc == 32'h4) begin
            chk("opcode_8c22", 32'(id_opcode), 32'(6'b100011));
            chk("funct_8c22", 32'(id_funct), 32'(6'b000100));
          end
        end
      end else if (!id_valid) begin
        chk("idle_zero", id_instr | id_pc | id_pc_plus4, 32'h0);
      end
    end
  end

  task automatic run_acc(input int n, input string name);
    int base = acc_cnt;
    bit ok = 1'b0;
    imem_req_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (acc_cnt - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
    imem_req_ready = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL acc_timeout_%s actual=%0d expected=%0d", name, acc_cnt - base, n);
    end
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (pend.size() == 0 && exp_pop.size() == 0 && exp_req.size() == 0 && !id_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_%s actual=pend%0d/pop%0d/req%0d expected=0/0/0", name, pend.size(),
               exp_pop.size(), exp_req.size());
      exp_pop.delete();
      exp_req.delete();
    end
  endtask

  initial begin
    int base;
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_bus", id_instr | id_pc | id_pc_plus4, 32'h0);

    // Streaming from RESET_PC with address wrap
    @(negedge clk);
    rst = 1'b0;
    id_ready = 1'b1;
    lat = 1;
    add_req(32'hFFFF_FFF8); add_req(32'hFFFF_FFFC); add_req(32'h0);
    add_req(32'h4);         add_req(32'h8);         add_req(32'hC);
    add_pop(32'hFFFF_FFF8, 32'hFFFF_FFFC); add_pop(32'hFFFF_FFFC, 32'h0);
    add_pop(32'h0, 32'h4); add_pop(32'h4, 32'h8); add_pop(32'h8, 32'hC); add_pop(32'hC, 32'h10);
    run_acc(6, "stream");
    drain("stream");
    chk("first_latency", 32'(first_vld - first_acc), 32'd2);

    // Decode stall: credit limit holds requests at two
    id_ready = 1'b0;
    base = acc_cnt;
    add_req(32'h10); add_req(32'h14);
    imem_req_ready = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    chk("stall_acc", 32'(acc_cnt - base), 32'd2);
    chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
    add_req(32'h18); add_req(32'h1C);
    add_pop(32'h10, 32'h14); add_pop(32'h14, 32'h18);
    add_pop(32'h18, 32'h1C); add_pop(32'h1C, 32'h20);
    id_ready = 1'b1;
    run_acc(2, "unstall");
    drain("unstall");

    // Redirect with two requests outstanding on a 3-cycle memory
    lat = 3;
    add_req(32'h20); add_req(32'h24); add_req(32'h100); add_req(32'h104);
    add_pop(32'h100, 32'h104); add_pop(32'h104, 32'h108);
    run_acc(2, "pre_redir");
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    run_acc(2, "post_redir");
    drain("redir");

    // Redirect coinciding with a response and a pop, unaligned target
    lat = 1;
    add_req(32'h108); add_req(32'h10C); add_req(32'h200); add_req(32'h204);
    add_pop(32'h200, 32'h204); add_pop(32'h204, 32'h208);
    run_acc(2, "pre_redir2");
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #2;
    chk("redir2_q_empty", 32'(id_valid), 32'h0);
    chk("redir2_req_addr", imem_req_addr, 32'h200);
    run_acc(2, "post_redir2");
    drain("redir2");

    // Reset mid-stream with one entry queued
    id_ready = 1'b0;
    add_req(32'h208); add_req(32'h20C);
    run_acc(2, "pre_rst");
    chk("pre_rst_id_valid", 32'(id_valid), 32'h1);
    imem_req_ready = 1'b1;
    rst = 1'b1;
    #2;
    chk("mid_rst_id_valid", 32'(id_valid), 32'h0);
    chk("mid_rst_id_instr", id_instr, 32'h0);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
    imem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    id_ready = 1'b1;
    add_req(32'hFFFF_FFF8); add_req(32'hFFFF_FFFC);
    add_pop(32'hFFFF_FFF8, 32'hFFFF_FFFC); add_pop(32'hFFFF_FFFC, 32'h0);
    run_acc(2, "post_rst");
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
